// File: rtl/enc_snapshot_ctrl.sv
// enc_snapshot_ctrl: sweeps the encoder channel-select mux once per request and
// captures every channel's quad/period/qtr1/qtr5/run words into the inactive half
// of a double-buffered snapshot bank. The bank flips only after the last channel
// is captured, so host reads always see one time-coherent set.
module enc_snapshot_ctrl #(
    parameter int unsigned NUM_ENC = 4,
    parameter int unsigned SEQ_W   = 8
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               snap_req,
    input  logic               clr_ovr,
    output logic [3:0]         enc_chan,
    input  logic [31:0]        enc_quad,
    input  logic [31:0]        enc_perd,
    input  logic [31:0]        enc_qtr1,
    input  logic [31:0]        enc_qtr5,
    input  logic [31:0]        enc_run,
    input  logic [3:0]         rd_chan,
    input  logic [2:0]         rd_word,
    output logic [31:0]        rd_data,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic [SEQ_W-1:0]   snap_seq
);

    localparam int unsigned CHAN_W    = 4;
    localparam int unsigned WSEL_W    = 3;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_WORDS = 5;
    localparam int unsigned NUM_BANKS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                act_q, act_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;

    logic                capture_c;
    logic                last_c;
    logic                ovr_set_c;
    logic [DATA_W-1:0]   word_c [NUM_WORDS];

    logic [DATA_W-1:0]   bank_q [NUM_BANKS][NUM_ENC][NUM_WORDS];

    // Capture happens on every edge spent in SCAN; the last channel closes the sweep.
    assign capture_c = (state_q == ST_SCAN);
    assign last_c    = (chan_q == CHAN_W'(NUM_ENC));

    // Gather the encoder words for the currently selected channel in read-word order.
    always_comb begin
        word_c[0] = enc_quad;
        word_c[1] = enc_perd;
        word_c[2] = enc_qtr1;
        word_c[3] = enc_qtr5;
        word_c[4] = enc_run;
    end

    // Next-state and control decode for the scan sequencer.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        act_d     = act_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        seq_d     = seq_q;
        ovr_set_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    state_d = ST_SCAN;
                    chan_d  = CHAN_W'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (last_c) begin
                    act_d   = ~act_q;
                    seq_d   = seq_q + SEQ_W'(1);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    chan_d  = CHAN_W'(1);
                    state_d = ST_DONE;
                end else begin
                    chan_d  = chan_q + CHAN_W'(1);
                end
                // One request may queue behind a running sweep; a further one is lost.
                if (snap_req) begin
                    if (!pend_q) begin
                        pend_d = 1'b1;
                    end else begin
                        ovr_set_c = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (snap_req || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_SCAN;
                    chan_d  = CHAN_W'(1);
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                chan_d  = CHAN_W'(1);
                busy_d  = 1'b0;
            end
        endcase

        // A dropped request beats a simultaneous clear.
        if (ovr_set_c) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // Sequencer state and control registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            chan_q  <= CHAN_W'(1);
            act_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seq_q   <= seq_d;
        end
    end

    // Snapshot storage: the sweep writes only the bank the host is not reading.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int c = 0; c < int'(NUM_ENC); c++) begin
                    for (int w = 0; w < int'(NUM_WORDS); w++) begin
                        bank_q[b][c][w] <= '0;
                    end
                end
            end
        end else if (capture_c) begin
            for (int c = 0; c < int'(NUM_ENC); c++) begin
                if (chan_q == CHAN_W'(c + 1)) begin
                    for (int w = 0; w < int'(NUM_WORDS); w++) begin
                        bank_q[~act_q][c][w] <= word_c[w];
                    end
                end
            end
        end
    end

    // Host read mux over the active bank; unmapped channel/word selects read zero.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < int'(NUM_ENC); c++) begin
            for (int w = 0; w < int'(NUM_WORDS); w++) begin
                if ((rd_chan == CHAN_W'(c + 1)) && (rd_word == WSEL_W'(w))) begin
                    rd_data = bank_q[act_q][c][w];
                end
            end
        end
    end

    assign enc_chan = chan_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = ovr_q;
    assign snap_seq = seq_q;

endmodule

// File: doc/enc_snapshot_ctrl.md
Name: enc_snapshot_ctrl

Overview:
- Scheduler that sweeps the encoder channel-select mux across all channels and captures each channel's quad, period, qtr1, qtr5 and run words into a double-buffered snapshot bank.
- Host block reads return a time-coherent set for all channels; reads are never torn by a concurrent update.
- Sits between the encoder control block, whose combinational outputs are indexed by enc_chan, and the host read decode. A snapshot is requested by a read-start or timer pulse.

Parameters:
- NUM_ENC, 4, number of encoder channels, 1..15; channels are numbered 1..NUM_ENC.
- SEQ_W, 8, width of the completed-snapshot sequence counter.

Ports:
- sysclk  in  1  global clock.
- reset  in  1  asynchronous, active-high reset.
- snap_req  in  1  single-cycle snapshot request.
- clr_ovr  in  1  clears the overrun flag.
- enc_chan  out  4  channel select driven to the encoder block's read mux.
- enc_quad  in  32  quad word for enc_chan; combinational, valid in the same cycle.
- enc_perd  in  32  period word for enc_chan.
- enc_qtr1  in  32  qtr1 word for enc_chan.
- enc_qtr5  in  32  qtr5 word for enc_chan.
- enc_run  in  32  run word for enc_chan.
- rd_chan  in  4  host read channel.
- rd_word  in  3  host word select: 0 quad, 1 perd, 2 qtr1, 3 qtr5, 4 run.
- rd_data  out  32  selected word from the active bank; combinational.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a new bank becomes active.
- overrun  out  1  sticky flag: a request was dropped.
- snap_seq  out  SEQ_W  count of completed snapshots.

Behaviour:
- Reset values:
  - State is IDLE.
  - enc_chan is 4'd1; busy, done and overrun are 0; snap_seq is 0.
  - Both banks are cleared to 0; the active bank is bank 0; pending is 0.
  - Reset mid-scan aborts immediately. Partial capture is discarded because both banks are cleared.
- States and transitions:
  - IDLE: on snap_req, go to SCAN with enc_chan=1 and busy=1.
  - SCAN: at every edge, write enc_quad, enc_perd, enc_qtr1, enc_qtr5 and enc_run for the current enc_chan into the inactive bank, then increment enc_chan.
    - At the edge that captures channel NUM_ENC: toggle the active bank, increment snap_seq (wraps modulo 2^SEQ_W), set done=1, set busy=0, set enc_chan=1, go to DONE.
  - DONE: lasts one cycle.
    - If snap_req or pending is set, clear pending and go to SCAN with busy=1.
    - Otherwise go to IDLE.
    - done deasserts at the next edge in both cases.
- Timing:
  - Request sampled at edge E0; channel k is captured at edge Ek.
  - done is high in the cycle after edge E_NUM_ENC, i.e. NUM_ENC+1 cycles of latency from the request edge.
- Request while busy:
  - If pending=0, set pending; the request is serviced from DONE.
  - If pending=1, the request is dropped and overrun is set.
- Overrun clearing:
  - clr_ovr clears overrun.
  - clr_ovr and a dropping request in the same cycle leave overrun set; set wins.
- Read port:
  - rd_data always reads the active bank.
  - It changes to the new snapshot in the same cycle done rises.
  - rd_chan=0, rd_chan>NUM_ENC or rd_word>4 returns 32'd0.
- snap_req in the same cycle as reset is ignored.

Test Plan:
- Reset, then read ch1 word0 -> 0; busy=0, enc_chan=1, snap_seq=0.
- Encoder model returns 32'hC0000000+{chan,word}, pulse snap_req at E0 (NUM_ENC=4) -> enc_chan steps 1,2,3,4 during E0..E4; done high only in the cycle after E4; snap_seq=1; ch3 word4 reads 32'hC0000034.
- During the scan, hold rd_chan=2, rd_word=1 -> old-bank value is stable until the done cycle, then the new value appears.
- Second snap_req at E2 -> pending is set; DONE transitions directly to SCAN; second done 5 cycles after the first; snap_seq=2; overrun=0.
- snap_req at E1, E2 and E3 -> one request is pending, overrun=1 after E3; clr_ovr pulse -> overrun=0; clr_ovr coincident with a dropped request -> overrun stays 1.
- Assert reset at E2 of a scan -> busy and done are 0 asynchronously, all reads return 0, snap_seq=0; the next snap_req completes normally with snap_seq=1.
